// File: rtl/song_guide_ctrl.sv
// Song guide sequencer: walks the song ROM and drives the LED guide note,
// in auto (beat-timed) or learn (wait-for-key, hit/miss counting) mode.
module song_guide_ctrl #(
  parameter int ADDR_W        = 6,
  parameter int CLK_PER_BEAT  = 25000000,
  parameter int GAP_CYCLES    = 2500000,
  parameter int TIMEOUT_BEATS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              mode,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_note,
  input  logic [3:0]        rom_dur,
  input  logic [6:0]        key_in,
  output logic [3:0]        song_note,
  output logic              playing,
  output logic              done,
  output logic [7:0]        hit_count,
  output logic [7:0]        miss_count
);

  localparam int CYC_MAX  = (CLK_PER_BEAT > GAP_CYCLES) ? CLK_PER_BEAT : GAP_CYCLES;
  localparam int CYC_W    = $clog2(CYC_MAX + 1);
  localparam int BEAT_MAX = (TIMEOUT_BEATS > 15) ? TIMEOUT_BEATS : 15;
  localparam int BEAT_W   = $clog2(BEAT_MAX + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_READ   = 3'd2;
  localparam logic [2:0] S_PLAY   = 3'd3;
  localparam logic [2:0] S_GAP    = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  logic [2:0]        state;
  logic              mode_r;
  logic [6:0]        key_prev;
  logic [CYC_W-1:0]  cyc_cnt;
  logic [BEAT_W-1:0] beat_cnt;
  logic [BEAT_W-1:0] beat_lim;

  logic [3:0] rd_note;
  logic [3:0] rd_dur;
  logic [6:0] note_onehot;
  logic       learn_note;
  logic       hit;
  logic       beat_end;
  logic       last_beat;
  logic       gap_end;

  always_comb begin
    rd_note = (rom_note <= 4'd7) ? rom_note : 4'd0;
    rd_dur  = (rom_dur == 4'd0) ? 4'd1 : rom_dur;
    note_onehot = '0;
    for (int unsigned i = 1; i <= 7; i++) begin
      if (song_note == 4'(i)) note_onehot[3'(7 - i)] = 1'b1;
    end
    // song_note is non-zero only for real notes, so it doubles as the "key-checked" flag
    learn_note = mode_r && (song_note != 4'd0);
    hit        = learn_note && (key_in == note_onehot) && ((key_prev & note_onehot) == '0);
    beat_end   = (cyc_cnt == CYC_W'(CLK_PER_BEAT - 1));
    last_beat  = (beat_cnt == beat_lim - BEAT_W'(1));
    gap_end    = (cyc_cnt == CYC_W'(GAP_CYCLES - 1));
  end

  assign done = (state == S_FINISH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      mode_r     <= 1'b0;
      key_prev   <= '0;
      cyc_cnt    <= '0;
      beat_cnt   <= '0;
      beat_lim   <= '0;
      rom_addr   <= '0;
      song_note  <= '0;
      playing    <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      key_prev <= key_in;
      if (stop && state != S_IDLE) begin
        state     <= S_IDLE;
        song_note <= '0;
        playing   <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !stop) begin
              rom_addr   <= '0;
              hit_count  <= '0;
              miss_count <= '0;
              mode_r     <= mode;
              playing    <= 1'b1;
              state      <= S_LOAD;
            end
          end
          S_LOAD: state <= S_READ;
          S_READ: begin
            if (rom_note == 4'hF) begin
              song_note <= '0;
              playing   <= 1'b0;
              state     <= S_FINISH;
            end else begin
              song_note <= rd_note;
              beat_lim  <= (mode_r && rd_note != 4'd0) ? BEAT_W'(TIMEOUT_BEATS) : BEAT_W'(rd_dur);
              beat_cnt  <= '0;
              cyc_cnt   <= '0;
              state     <= S_PLAY;
            end
          end
          S_PLAY: begin
            if (hit || (beat_end && last_beat)) begin
              if (hit)
                hit_count <= hit_count + {7'd0, hit_count != 8'hFF};
              else if (learn_note)
                miss_count <= miss_count + {7'd0, miss_count != 8'hFF};
              song_note <= '0;
              cyc_cnt   <= '0;
              state     <= S_GAP;
            end else if (beat_end) begin
              cyc_cnt  <= '0;
              beat_cnt <= beat_cnt + BEAT_W'(1);
            end else begin
              cyc_cnt <= cyc_cnt + CYC_W'(1);
            end
          end
          S_GAP: begin
            if (gap_end) begin
              if (rom_addr == '1) begin
                playing <= 1'b0;
                state   <= S_FINISH;
              end else begin
                rom_addr <= rom_addr + ADDR_W'(1);
                state    <= S_LOAD;
              end
            end else begin
              cyc_cnt <= cyc_cnt + CYC_W'(1);
            end
          end
          S_FINISH: state <= S_IDLE;
          default:  state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_song_guide_ctrl.sv
// Directed bench for song_guide_ctrl with a small synchronous song ROM model.
module tb_song_guide_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, stop, mode;
  logic [2:0] rom_addr;
  logic [3:0] rom_note, rom_dur;
  logic [6:0] key_in;
  logic [3:0] song_note;
  logic       playing, done;
  logic [7:0] hit_count, miss_count;

  logic [3:0] mem_note [8];
  logic [3:0] mem_dur  [8];

  int n_cmp = 0;
  int n_bad = 0;
  int n = 0;

  song_guide_ctrl #(
    .ADDR_W(3),
    .CLK_PER_BEAT(4),
    .GAP_CYCLES(2),
    .TIMEOUT_BEATS(3)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .rom_addr(rom_addr), .rom_note(rom_note), .rom_dur(rom_dur),
    .key_in(key_in), .song_note(song_note), .playing(playing), .done(done),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_note <= mem_note[rom_addr];
    rom_dur  <= mem_dur[rom_addr];
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, n);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic run_to(input int t);
    while (n < t) tick();
  endtask

  task automatic go(input logic m);
    start = 1'b1;
    mode  = m;
    tick();
    start = 1'b0;
    n = 0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 8; i++) begin
      mem_note[i] = 4'hF;
      mem_dur[i]  = 4'd0;
    end
  endtask

  task automatic set_rom(input int i, input int nt, input int d);
    mem_note[i] = 4'(nt);
    mem_dur[i]  = 4'(d);
  endtask

  task automatic note_span(input string tag, input int a, input int b, input int v);
    for (int i = a; i <= b; i++) begin
      run_to(i);
      chk(tag, song_note, v);
    end
  endtask

  task automatic settle();
    key_in = '0;
    repeat (3) tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; key_in = '0;
    clear_rom();
    tick(); tick();
    rst = 1'b0;
    chk("rst_note", song_note, 0);
    chk("rst_playing", playing, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", rom_addr, 0);
    chk("rst_hits", hit_count, 0);
    chk("rst_miss", miss_count, 0);

    // Auto mode: (1,2),(3,1),end
    clear_rom(); set_rom(0, 1, 2); set_rom(1, 3, 1);
    go(1'b0);
    chk("auto_playing", playing, 1);
    note_span("auto_pre", 0, 1, 0);
    note_span("auto_n1", 2, 9, 1);
    note_span("auto_gap1", 10, 13, 0);
    note_span("auto_n3", 14, 17, 3);
    note_span("auto_gap2", 18, 21, 0);
    chk("auto_done_early", done, 0);
    run_to(22);
    chk("auto_done", done, 1);
    chk("auto_play_fall", playing, 0);
    chk("auto_hits", hit_count, 0);
    chk("auto_miss", miss_count, 0);
    run_to(23);
    chk("auto_done_pulse", done, 0);
    settle();

    // Learn: hit on fresh press, held key gives no second hit
    clear_rom(); set_rom(0, 5, 1); set_rom(1, 5, 1);
    go(1'b1);
    run_to(3);
    chk("learn_n5", song_note, 5);
    key_in = 7'b0000100;
    run_to(4);
    chk("learn_hit", hit_count, 1);
    chk("learn_hit_dark", song_note, 0);
    note_span("learn_held", 8, 19, 5);
    chk("learn_no_miss_yet", miss_count, 0);
    run_to(20);
    chk("learn_miss", miss_count, 1);
    chk("learn_hit_hold", hit_count, 1);
    run_to(24);
    chk("learn_done", done, 1);
    settle();

    // Learn: key held from before start, released and re-pressed -> hit
    key_in = 7'b0000100;
    tick(); tick();
    go(1'b1);
    run_to(3);
    chk("repress_nohit", hit_count, 0);
    key_in = '0;
    run_to(4);
    chk("repress_still", song_note, 5);
    key_in = 7'b0000100;
    run_to(5);
    chk("repress_hit", hit_count, 1);
    chk("repress_dark", song_note, 0);
    run_to(21);
    chk("repress_miss", miss_count, 1);
    run_to(25);
    chk("repress_done", done, 1);
    settle();

    // Learn: chord and wrong key never hit
    clear_rom(); set_rom(0, 5, 1);
    go(1'b1);
    run_to(2);
    key_in = 7'b1000100;
    run_to(6);
    key_in = 7'b1000000;
    run_to(9);
    key_in = '0;
    run_to(13);
    chk("chord_note", song_note, 5);
    run_to(14);
    chk("chord_hits", hit_count, 0);
    chk("chord_miss", miss_count, 1);
    run_to(18);
    chk("chord_done", done, 1);
    settle();

    // Rests, note 9, dur 0 (auto)
    clear_rom(); set_rom(0, 0, 1); set_rom(1, 9, 2); set_rom(2, 3, 0);
    go(1'b0);
    note_span("rest_dark", 2, 21, 0);
    note_span("dur0_n3", 22, 25, 3);
    run_to(26);
    chk("dur0_end", song_note, 0);
    run_to(29);
    chk("rest_done_early", done, 0);
    run_to(30);
    chk("rest_done", done, 1);
    settle();

    // Same ROM in learn mode: rests follow rom_dur, keys ignored there
    go(1'b1);
    run_to(2);
    key_in = 7'b0010000;
    run_to(15);
    key_in = '0;
    run_to(21);
    chk("lrest_hits", hit_count, 0);
    chk("lrest_miss", miss_count, 0);
    run_to(22);
    chk("lrest_n3", song_note, 3);
    run_to(23);
    key_in = 7'b0010000;
    run_to(24);
    chk("lrest_hit", hit_count, 1);
    run_to(28);
    chk("lrest_done", done, 1);
    settle();

    // Full ROM, no end marker
    for (int i = 0; i < 8; i++) set_rom(i, (i % 7) + 1, 1);
    go(1'b0);
    run_to(2);
    chk("full_n0", song_note, 1);
    run_to(10);
    chk("full_n1", song_note, 2);
    run_to(56);
    chk("full_addr7", rom_addr, 7);
    run_to(57);
    chk("full_read7", song_note, 0);
    run_to(58);
    chk("full_n7", song_note, 1);
    run_to(63);
    chk("full_gap7", done, 0);
    run_to(64);
    chk("full_done", done, 1);
    chk("full_play_fall", playing, 0);
    chk("full_addr_hold", rom_addr, 7);
    run_to(65);
    chk("full_done_pulse", done, 0);
    chk("full_addr_final", rom_addr, 7);
    settle();

    // stop mid-PLAY in learn mode; counters and address hold
    clear_rom(); set_rom(0, 5, 1); set_rom(1, 5, 1);
    go(1'b1);
    run_to(3);
    key_in = 7'b0000100;
    run_to(10);
    chk("stop_pre_note", song_note, 5);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_note", song_note, 0);
    chk("stop_playing", playing, 0);
    chk("stop_done", done, 0);
    chk("stop_addr", rom_addr, 1);
    chk("stop_hits", hit_count, 1);
    run_to(40);
    chk("stop_no_done", done, 0);
    chk("stop_idle_note", song_note, 0);

    // start and stop together in IDLE are rejected
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("ss_playing", playing, 0);
    chk("ss_hits_kept", hit_count, 1);
    tick(); tick();
    chk("ss_note", song_note, 0);
    settle();

    // rst mid-song
    go(1'b1);
    run_to(3);
    key_in = 7'b0000100;
    run_to(10);
    chk("rst_pre_addr", rom_addr, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_note", song_note, 0);
    chk("mrst_playing", playing, 0);
    chk("mrst_addr", rom_addr, 0);
    chk("mrst_hits", hit_count, 0);
    chk("mrst_done", done, 0);
    settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
